key_decoder_param: RTL and testbench

Parametrised serial key decoder for the controller. It shifts in a KEY_W-bit secret followed by MODE_W mode bits, one bit per ValidCmd strobe. On a full, correct frame it asserts Active and holds the received Mode. Failed frames are counted, and an optional lockout interval follows MAX_FAIL consecutive failures.

---
 rtl/key_decoder_pkg.sv | 29 ++
 rtl/key_lockout_timer.sv | 43 ++++
 rtl/key_decoder_param.sv | 181 ++++++++++++++++++
 tb/tb_key_decoder_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_decoder_pkg.sv
// -----------------------------------------------------------------------------
// key_decoder_pkg
//   Shared types and width helpers for the serial key decoder.
//   - key_state_t    : decoder FSM states
//   - bit_cnt_width  : width of the frame bit counter, $clog2(KEY_W+MODE_W+1)
//   - lock_cnt_width : width of the lockout timer, $clog2(LOCK_CYCLES+1)
// -----------------------------------------------------------------------------
package key_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RX     = 2'd1,
    ACTIVE = 2'd2,
    LOCKED = 2'd3
  } key_state_t;

  function automatic int bit_cnt_width(input int key_w, input int mode_w);
    return $clog2(key_w + mode_w + 1);
  endfunction

  function automatic int lock_cnt_width(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

  // Widths for the default configuration (KEY_W=4, MODE_W=1, LOCK_CYCLES=16).
  localparam int DEF_BIT_CNT_W  = bit_cnt_width(4, 1);
  localparam int DEF_LOCK_CNT_W = lock_cnt_width(16);

endpackage

// File: rtl/key_lockout_timer.sv
// -----------------------------------------------------------------------------
// key_lockout_timer
//   Down-counter that measures the lockout interval. Only instantiated when
//   KEYDEC_LOCKOUT_EN is defined.
//   Ports:
//     Clk   - clock, rising edge
//     Reset - asynchronous, active-low reset
//     start - load the timer with LOCK_CYCLES
//     busy  - timer is running
//     done  - high during the last cycle of the interval (single cycle)
//   Timing: start sampled on edge E0 -> busy for cycles 1..LOCK_CYCLES, done
//   during cycle LOCK_CYCLES so the owner can leave lockout on edge E(LOCK_CYCLES).
// -----------------------------------------------------------------------------
module key_lockout_timer
  import key_decoder_pkg::*;
#(
  parameter int LOCK_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CW = lock_cnt_width(LOCK_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(LOCK_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/key_decoder_param.sv
// -----------------------------------------------------------------------------
// key_decoder_param
//   Serial key decoder. Shifts in a KEY_W-bit secret followed by MODE_W mode
//   bits (both MSB-first), one bit per ValidCmd. A correct frame raises Active
//   and holds Mode until Clear; a wrong frame pulses Error and bumps FailCnt.
//   Optional feature macro: KEYDEC_LOCKOUT_EN -- when defined, MAX_FAIL
//   consecutive failures enter a LOCKED state for LOCK_CYCLES cycles.
//   Ports:
//     Clk      - clock, rising edge
//     Reset    - asynchronous, active-low reset
//     ValidCmd - InputKey is valid this cycle
//     InputKey - serial key/mode bit
//     Clear    - abort current frame / deactivate
//     Active   - correct key received, held until Clear
//     Mode     - received mode field while Active, else 0
//     Error    - one-cycle pulse per failed frame
//     Locked   - lockout in progress (tied 0 without KEYDEC_LOCKOUT_EN)
//     FailCnt  - consecutive failed frames, saturating at MAX_FAIL
//   All outputs are registered.
// -----------------------------------------------------------------------------
module key_decoder_param
  import key_decoder_pkg::*;
#(
  parameter int               KEY_W       = 4,
  parameter logic [KEY_W-1:0] SECRET      = 4'b0101,
  parameter int               MODE_W      = 1,
  parameter int               MAX_FAIL    = 3,
  parameter int               LOCK_CYCLES = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           ValidCmd,
  input  logic                           InputKey,
  input  logic                           Clear,
  output logic                           Active,
  output logic [MODE_W-1:0]              Mode,
  output logic                           Error,
  output logic                           Locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]  FailCnt
);

  localparam int FRAME_W = KEY_W + MODE_W;
  localparam int CNT_W   = bit_cnt_width(KEY_W, MODE_W);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

  key_state_t          state;
  // Holds every received bit except the one arriving this cycle; the final
  // bit is taken straight from InputKey when the frame is evaluated.
  logic [FRAME_W-2:0]  shift;
  logic [CNT_W-1:0]    bit_cnt;

  logic [FRAME_W-1:0]  frame;
  logic                key_ok;
  logic                last_bit;
  logic                take_bit;
  logic [FAIL_W-1:0]   fail_next;
  logic                fail_limit;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    frame      = {shift, InputKey};
    key_ok     = (frame[FRAME_W-1 -: KEY_W] == SECRET);
    last_bit   = (bit_cnt == CNT_W'(FRAME_W - 1));
    take_bit   = ValidCmd && !Clear;
    fail_next  = (FailCnt == FAIL_W'(MAX_FAIL)) ? FailCnt : FailCnt + FAIL_W'(1);
    fail_limit = (fail_next == FAIL_W'(MAX_FAIL));
  end

`ifdef KEYDEC_LOCKOUT_EN
  logic lock_start;
  logic lock_busy;
  logic lock_done;

  // Timer is armed on the same edge that records the MAX_FAIL-th failure.
  assign lock_start = (state == RX) && take_bit && last_bit && !key_ok && fail_limit;

  key_lockout_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .start (lock_start),
    .busy  (lock_busy),
    .done  (lock_done)
  );
`else
  assign Locked = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      Active  <= 1'b0;
      Mode    <= '0;
      Error   <= 1'b0;
      FailCnt <= '0;
`ifdef KEYDEC_LOCKOUT_EN
      Locked  <= 1'b0;
`endif
    end else begin
      Error <= 1'b0;  // single-cycle pulse unless a frame fails this edge

      case (state)
        IDLE: begin
          // Clear has priority, so a simultaneous bit is discarded.
          if (take_bit) begin
            shift   <= frame[FRAME_W-2:0];
            bit_cnt <= CNT_W'(1);
            state   <= RX;
          end
        end

        RX: begin
          if (Clear) begin
            // Abort: frame discarded silently, failure history kept.
            bit_cnt <= '0;
            state   <= IDLE;
          end else if (ValidCmd) begin
            shift <= frame[FRAME_W-2:0];
            if (last_bit) begin
              // Evaluated only after the mode bits too, so frame length
              // never depends on where the key went wrong.
              bit_cnt <= '0;
              if (key_ok) begin
                state   <= ACTIVE;
                Active  <= 1'b1;
                Mode    <= frame[MODE_W-1:0];
                FailCnt <= '0;
              end else begin
                Error   <= 1'b1;
                FailCnt <= fail_next;
`ifdef KEYDEC_LOCKOUT_EN
                if (fail_limit) begin
                  state  <= LOCKED;
                  Locked <= 1'b1;
                end else begin
                  state  <= IDLE;
                end
`else
                state   <= IDLE;
`endif
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        ACTIVE: begin
          if (Clear) begin
            Active <= 1'b0;
            Mode   <= '0;
            state  <= IDLE;
          end
        end

        LOCKED: begin
`ifdef KEYDEC_LOCKOUT_EN
          // ValidCmd and Clear are ignored; leave only when the timer expires.
          // The !lock_busy term recovers if the timer was ever found idle here.
          if (lock_done || !lock_busy) begin
            Locked  <= 1'b0;
            FailCnt <= '0;
            state   <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_decoder_param.sv
// -----------------------------------------------------------------------------
// tb_key_decoder_param
//   Directed bench for key_decoder_param: a default-parameter instance and a
//   wide instance (KEY_W=8, SECRET=8'hA5, MODE_W=2). Inputs change 1 time unit
//   after the rising edge; outputs are compared at the same point.
//   Packed observation {Active, Mode, Error, Locked, FailCnt}.
// -----------------------------------------------------------------------------
module tb_key_decoder_param;

`ifdef KEYDEC_LOCKOUT_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ValidCmd = 1'b0, InputKey = 1'b0, Clear = 1'b0;
  logic       Active, Error, Locked;
  logic [0:0] Mode;
  logic [1:0] FailCnt;

  logic       ValidCmd8 = 1'b0, InputKey8 = 1'b0, Clear8 = 1'b0;
  logic       Active8, Error8, Locked8;
  logic [1:0] Mode8;
  logic [1:0] FailCnt8;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] outs;
  logic [6:0] outs8;
  logic [5:0] exp;
  logic [6:0] exp8;

  assign outs  = {Active, Mode, Error, Locked, FailCnt};
  assign outs8 = {Active8, Mode8, Error8, Locked8, FailCnt8};

  always #5 Clk = ~Clk;

  key_decoder_param dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ValidCmd (ValidCmd),
    .InputKey (InputKey),
    .Clear    (Clear),
    .Active   (Active),
    .Mode     (Mode),
    .Error    (Error),
    .Locked   (Locked),
    .FailCnt  (FailCnt)
  );

  key_decoder_param #(
    .KEY_W  (8),
    .SECRET (8'hA5),
    .MODE_W (2)
  ) dut8 (
    .Clk      (Clk),
    .Reset    (Reset),
    .ValidCmd (ValidCmd8),
    .InputKey (InputKey8),
    .Clear    (Clear8),
    .Active   (Active8),
    .Mode     (Mode8),
    .Error    (Error8),
    .Locked   (Locked8),
    .FailCnt  (FailCnt8)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ValidCmd = 1'b1;
    InputKey = b;
    step();
    ValidCmd = 1'b0;
    InputKey = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic clear_pulse();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
  endtask

  task automatic send_bit8(input logic b, input int gap);
    ValidCmd8 = 1'b1;
    InputKey8 = b;
    step();
    ValidCmd8 = 1'b0;
    InputKey8 = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_frame8(input logic [15:0] bits, input int gap);
    for (int i = 9; i >= 0; i--) send_bit8(bits[i], (i == 0) ? 0 : gap);
  endtask

  task automatic test_reset();
    step();
    step();
    exp = 6'b000000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL reset_held: observed %b expected %b", outs, exp); end
    exp8 = 7'b0000000; n_vec++;
    if (outs8 !== exp8) begin n_err++; $display("FAIL reset_held_wide: observed %b expected %b", outs8, exp8); end
    Reset = 1'b1;
    step();
    n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL reset_release: observed %b expected %b", outs, exp); end
  endtask

  task automatic test_good_frame();
    send_bits(16'b0101, 4);
    exp = 6'b000000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL good_before_last: observed %b expected %b", outs, exp); end
    send_bit(1'b1);
    exp = 6'b110000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL good_active: observed %b expected %b", outs, exp); end
    send_bit(1'b0);  // ignored while ACTIVE
    n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL good_hold: observed %b expected %b", outs, exp); end
    clear_pulse();
    exp = 6'b000000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL good_clear: observed %b expected %b", outs, exp); end
  endtask

  task automatic test_bad_frame();
    send_bits(16'b01110, 5);
    exp = 6'b001001; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL bad_error: observed %b expected %b", outs, exp); end
    step();
    exp = 6'b000001; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL bad_pulse_end: observed %b expected %b", outs, exp); end
    send_bits(16'b01011, 5);
    exp = 6'b110000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL bad_then_good: observed %b expected %b", outs, exp); end
    clear_pulse();
  endtask

  task automatic test_back_to_back();
    send_bits(16'b11110, 5);
    exp = 6'b001001; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL b2b_error: observed %b expected %b", outs, exp); end
    send_bits(16'b01010, 5);  // starts the very next cycle, mode 0
    exp = 6'b100000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL b2b_active: observed %b expected %b", outs, exp); end
    clear_pulse();
  endtask

  task automatic test_lockout();
    send_bits(16'b00000, 5);
    send_bits(16'b00000, 5);
    exp = 6'b001010; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL lock_second_fail: observed %b expected %b", outs, exp); end
    send_bits(16'b00000, 5);
    exp = {1'b0, 1'b0, 1'b1, LOCK_EN, 2'd3}; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL lock_third_fail: observed %b expected %b", outs, exp); end
`ifdef KEYDEC_LOCKOUT_EN
    send_bits(16'b01011, 5);  // correct frame during lockout: ignored
    exp = 6'b000111; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL lock_ignore: observed %b expected %b", outs, exp); end
    repeat (10) step();       // 15 cycles of lockout elapsed
    n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL lock_still: observed %b expected %b", outs, exp); end
    step();                   // 16th edge leaves lockout
    exp = 6'b000000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL lock_release: observed %b expected %b", outs, exp); end
    send_bits(16'b01011, 5);  // first bit in the first IDLE cycle
    exp = 6'b110000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL lock_after_good: observed %b expected %b", outs, exp); end
`else
    send_bits(16'b00000, 5);
    exp = 6'b001011; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL nolock_saturate: observed %b expected %b", outs, exp); end
    send_bits(16'b01011, 5);
    exp = 6'b110000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL nolock_good: observed %b expected %b", outs, exp); end
`endif
    clear_pulse();
  endtask

  task automatic test_clear_abort();
    send_bits(16'b11111, 5);
    exp = 6'b001001; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL abort_setup: observed %b expected %b", outs, exp); end
    send_bits(16'b01, 2);
    Clear = 1'b1; ValidCmd = 1'b1; InputKey = 1'b0;
    step();
    Clear = 1'b0; ValidCmd = 1'b0;
    exp = 6'b000001; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL abort_no_error: observed %b expected %b", outs, exp); end
    send_bits(16'b01011, 5);
    exp = 6'b110000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL abort_then_good: observed %b expected %b", outs, exp); end
    clear_pulse();
  endtask

  task automatic test_reset_mid();
    send_bits(16'b00110, 5);
    send_bits(16'b010, 3);
    #2 Reset = 1'b0;
    #1;
    exp = 6'b000000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL rst_mid_frame: observed %b expected %b", outs, exp); end
    step();
    Reset = 1'b1;
    send_bits(16'b01011, 5);
    exp = 6'b110000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL rst_mid_good: observed %b expected %b", outs, exp); end
    #2 Reset = 1'b0;
    #1;
    exp = 6'b000000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL rst_active: observed %b expected %b", outs, exp); end
    step();
    Reset = 1'b1;
    send_bits(16'b01011, 5);
    exp = 6'b110000; n_vec++;
    if (outs !== exp) begin n_err++; $display("FAIL rst_active_good: observed %b expected %b", outs, exp); end
    clear_pulse();
  endtask

  task automatic test_wide();
    send_frame8(16'h0296, 0);  // A5, mode 2'b10
    exp8 = 7'b1100000; n_vec++;
    if (outs8 !== exp8) begin n_err++; $display("FAIL wide_active: observed %b expected %b", outs8, exp8); end
    Clear8 = 1'b1; step(); Clear8 = 1'b0;
    exp8 = 7'b0000000; n_vec++;
    if (outs8 !== exp8) begin n_err++; $display("FAIL wide_clear: observed %b expected %b", outs8, exp8); end
    send_frame8(16'h0292, 0);  // A4, mode 2'b10
    exp8 = 7'b0001001; n_vec++;
    if (outs8 !== exp8) begin n_err++; $display("FAIL wide_bad: observed %b expected %b", outs8, exp8); end
    send_frame8(16'h0296, 3);
    exp8 = 7'b1100000; n_vec++;
    if (outs8 !== exp8) begin n_err++; $display("FAIL wide_gaps: observed %b expected %b", outs8, exp8); end
    Clear8 = 1'b1; step(); Clear8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_back_to_back();
    test_lockout();
    test_clear_abort();
    test_reset_mid();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
